// File: rtl/sdr_target_frame_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_resp_pkg
//  Description : Shared types, constants and helpers for the SDR target-side
//                frame responder (state enum, broadcast address, ENTHDR base).
//  Revision    : 1.0 - initial release
// ============================================================================
package sdr_resp_pkg;

    // Frame-level states of the responder
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        ACK     = 3'd2,
        WDATA   = 3'd3,
        RIGNORE = 3'd4,
        HDR     = 3'd5
    } sdr_state_e;

    localparam logic [6:0] BCAST_ADDR  = 7'h7E;
    localparam logic [7:0] ENTHDR_BASE = 8'h20;

    // ENTHDR0..7 occupy one aligned block of eight codes
    function automatic logic is_enthdr(input logic [7:0] d);
        return d[7:3] == ENTHDR_BASE[7:3];
    endfunction

    // T-bit carries odd parity over the data byte
    function automatic logic parity_ok(input logic [7:0] d, input logic t);
        return t == ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdr_target_frame_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_target_frame_responder_if
//  Description : Bus-side and status signals of the SDR frame responder.
//                slave = the responder, master = whoever drives the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdr_target_frame_responder_if #(
    parameter int N_ADDR = 4
);
    logic                  i_en;
    logic                  i_scl;
    logic                  i_sda;
    logic [7*N_ADDR-1:0]   i_addr_tbl;
    logic [N_ADDR-1:0]     i_addr_vld;
    logic                  i_bcast_ack_en;
    logic                  i_hdr_exit;

    logic                  o_sda_low;
    logic [6:0]            o_addr;
    logic                  o_rnw;
    logic                  o_addr_valid;
    logic                  o_acked;
    logic [7:0]            o_data;
    logic                  o_data_valid;
    logic                  o_parity_err;
    logic                  o_ccc_valid;
    logic                  o_enthdr;
    logic [2:0]            o_hdr_mode;
    logic                  o_in_hdr;
    logic [4:0]            o_byte_cnt;
    logic                  o_overflow;

    modport slave (
        input  i_en, i_scl, i_sda, i_addr_tbl, i_addr_vld, i_bcast_ack_en, i_hdr_exit,
        output o_sda_low, o_addr, o_rnw, o_addr_valid, o_acked, o_data, o_data_valid,
               o_parity_err, o_ccc_valid, o_enthdr, o_hdr_mode, o_in_hdr, o_byte_cnt,
               o_overflow
    );

    modport master (
        output i_en, i_scl, i_sda, i_addr_tbl, i_addr_vld, i_bcast_ack_en, i_hdr_exit,
        input  o_sda_low, o_addr, o_rnw, o_addr_valid, o_acked, o_data, o_data_valid,
               o_parity_err, o_ccc_valid, o_enthdr, o_hdr_mode, o_in_hdr, o_byte_cnt,
               o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/sdr_target_frame_responder_cond_detect.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_bus_cond_detect
//  Description : SCL/SDA synchroniser plus SCL edge and START/Sr/STOP
//                detection on the synchronised lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdr_bus_cond_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  wire  i_sdr_clk,
    input  wire  i_sdr_rst_n,
    input  wire  i_scl,
    input  wire  i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_sr,
    output logic o_stop,
    output logic o_scl_lvl,
    output logic o_sda_lvl
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    // Synchroniser chains and one-clock history; reset to an idle (high) bus
    // so release from reset never looks like an edge.
    always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
        if (!i_sdr_rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // SDA edges only count as conditions when SCL was high on both samples
    always_comb begin
        o_scl_rise = w_scl & ~r_scl_prev;
        o_scl_fall = ~w_scl & r_scl_prev;
        o_start_sr = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
        o_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
        o_scl_lvl  = w_scl;
        o_sda_lvl  = w_sda;
    end

endmodule
`default_nettype wire

// File: rtl/sdr_target_frame_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_target_frame_responder
//  Description : SDR target-side frame responder: address decode and ACK,
//                9-bit write-word decode with parity, CCC / ENTHDRx detect.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdr_target_frame_responder
    import sdr_resp_pkg::*;
#(
    parameter int N_ADDR      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_HOLD    = 2,
    parameter int MAX_BYTES   = 16
) (
    input  wire                          i_sdr_clk,
    input  wire                          i_sdr_rst_n,
    sdr_target_frame_responder_if.slave  bus
);

    localparam int                  c_HOLD_W    = (ACK_HOLD < 2) ? 1 : $clog2(ACK_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(ACK_HOLD);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [31:0]         c_MAX_BYTES = 32'(MAX_BYTES);

    sdr_state_e             r_state;
    sdr_state_e             w_state_nxt;

    logic                   w_scl_rise, w_scl_fall, w_start_sr, w_stop, w_scl_lvl, w_sda_lvl;

    logic [8:0]             r_shift;
    logic [3:0]             r_bit_cnt;
    logic                   r_bcast_frame;
    logic [c_HOLD_W-1:0]    r_hold_cnt;
    logic                   r_hold_val;

    logic                   r_sda_low;
    logic [6:0]             r_addr;
    logic                   r_rnw;
    logic                   r_addr_valid;
    logic                   r_acked;
    logic [7:0]             r_data;
    logic                   r_data_valid;
    logic                   r_parity_err;
    logic                   r_ccc_valid;
    logic                   r_enthdr;
    logic [2:0]             r_hdr_mode;
    logic [4:0]             r_byte_cnt;
    logic                   r_overflow;

    logic                   w_framed, w_start_evt, w_stop_evt, w_hdr_leave;
    logic                   w_addr_done, w_ack_done, w_word_done;
    logic                   w_match, w_first_word, w_par_ok, w_enthdr_hit, w_bit_strobe;
    logic [6:0]             w_rx_addr;
    logic                   w_rx_rnw;
    logic [7:0]             w_rx_data;
    logic                   w_rx_t;
    logic [4:0]             w_cnt_inc;

    sdr_bus_cond_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cond (
        .i_sdr_clk   (i_sdr_clk),
        .i_sdr_rst_n (i_sdr_rst_n),
        .i_scl       (bus.i_scl),
        .i_sda       (bus.i_sda),
        .o_scl_rise  (w_scl_rise),
        .o_scl_fall  (w_scl_fall),
        .o_start_sr  (w_start_sr),
        .o_stop      (w_stop),
        .o_scl_lvl   (w_scl_lvl),
        .o_sda_lvl   (w_sda_lvl)
    );

    // Frame events derived from the current state and the line conditions
    assign w_framed     = (r_state == ADDR) || (r_state == ACK) ||
                          (r_state == WDATA) || (r_state == RIGNORE);
    assign w_start_evt  = w_start_sr && ((r_state == IDLE) || w_framed);
    assign w_stop_evt   = w_stop && (r_state != IDLE);
    assign w_hdr_leave  = (r_state == HDR) && bus.i_hdr_exit;
    assign w_bit_strobe = w_scl_rise && ((r_state == ADDR) || (r_state == WDATA));
    assign w_addr_done  = (r_state == ADDR) && w_scl_fall && (r_bit_cnt == 4'd8);
    assign w_ack_done   = (r_state == ACK) && w_scl_fall;
    assign w_word_done  = (r_state == WDATA) && w_scl_fall && (r_bit_cnt == 4'd9);
    assign w_rx_addr    = r_shift[7:1];
    assign w_rx_rnw     = r_shift[0];
    assign w_rx_data    = r_shift[8:1];
    assign w_rx_t       = r_shift[0];
    assign w_first_word = (r_byte_cnt == 5'd0);
    assign w_par_ok     = parity_ok(w_rx_data, w_rx_t);
    assign w_enthdr_hit = w_word_done && r_bcast_frame && w_first_word &&
                          is_enthdr(w_rx_data) && w_par_ok;
    assign w_cnt_inc    = (r_byte_cnt == 5'd31) ? 5'd31 : (r_byte_cnt + 5'd1);

    // Address match: broadcast write (when enabled) or any enabled table entry
    always_comb begin
        w_match = (w_rx_addr == BCAST_ADDR) && !w_rx_rnw && bus.i_bcast_ack_en;
        for (int k = 0; k < N_ADDR; k++) begin
            if (bus.i_addr_vld[k] && (bus.i_addr_tbl[7*k +: 7] == w_rx_addr)) begin
                w_match = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
        if (!i_sdr_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; STOP wins over everything, Sr restarts the address phase
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.i_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_evt) w_state_nxt = ADDR;
                end
                ADDR: begin
                    if (w_stop)           w_state_nxt = IDLE;
                    else if (w_start_sr)  w_state_nxt = ADDR;
                    else if (w_addr_done) w_state_nxt = w_match ? ACK : IDLE;
                end
                ACK: begin
                    if (w_stop)          w_state_nxt = IDLE;
                    else if (w_start_sr) w_state_nxt = ADDR;
                    else if (w_ack_done) w_state_nxt = r_rnw ? RIGNORE : WDATA;
                end
                WDATA: begin
                    if (w_stop)            w_state_nxt = IDLE;
                    else if (w_start_sr)   w_state_nxt = ADDR;
                    else if (w_enthdr_hit) w_state_nxt = HDR;
                end
                RIGNORE: begin
                    if (w_stop)          w_state_nxt = IDLE;
                    else if (w_start_sr) w_state_nxt = ADDR;
                end
                HDR: begin
                    if (w_stop || bus.i_hdr_exit) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Shifters, counters, decoded outputs and the SDA hold timer
    always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
        if (!i_sdr_rst_n) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_bcast_frame <= 1'b0;
            r_hold_cnt    <= '0;
            r_hold_val    <= 1'b0;
            r_sda_low     <= 1'b0;
            r_addr        <= '0;
            r_rnw         <= 1'b0;
            r_addr_valid  <= 1'b0;
            r_acked       <= 1'b0;
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_ccc_valid   <= 1'b0;
            r_enthdr      <= 1'b0;
            r_hdr_mode    <= '0;
            r_byte_cnt    <= '0;
            r_overflow    <= 1'b0;
        end else if (!bus.i_en) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_bcast_frame <= 1'b0;
            r_hold_cnt    <= '0;
            r_hold_val    <= 1'b0;
            r_sda_low     <= 1'b0;
            r_addr        <= '0;
            r_rnw         <= 1'b0;
            r_addr_valid  <= 1'b0;
            r_acked       <= 1'b0;
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_ccc_valid   <= 1'b0;
            r_enthdr      <= 1'b0;
            r_hdr_mode    <= '0;
            r_byte_cnt    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_addr_valid <= 1'b0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_ccc_valid  <= 1'b0;
            r_enthdr     <= 1'b0;

            // Pending SDA change; never applied while SCL is high, where it
            // would read as a START or STOP on the bus.
            if (r_hold_cnt != '0) begin
                if (r_hold_cnt == c_HOLD_ONE) begin
                    if (!w_scl_lvl) begin
                        r_sda_low  <= r_hold_val;
                        r_hold_cnt <= '0;
                    end
                end else begin
                    r_hold_cnt <= r_hold_cnt - c_HOLD_ONE;
                end
            end

            if (w_bit_strobe) begin
                r_shift   <= {r_shift[7:0], w_sda_lvl};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            if (w_addr_done) begin
                r_addr_valid  <= 1'b1;
                r_addr        <= w_rx_addr;
                r_rnw         <= w_rx_rnw;
                r_acked       <= w_match;
                r_bcast_frame <= (w_rx_addr == BCAST_ADDR) && !w_rx_rnw;
                r_bit_cnt     <= '0;
                if (w_match) begin
                    r_hold_cnt <= c_HOLD_LOAD;
                    r_hold_val <= 1'b1;
                end
            end

            if (w_ack_done) begin
                r_hold_cnt <= c_HOLD_LOAD;
                r_hold_val <= 1'b0;
                r_bit_cnt  <= '0;
            end

            if (w_word_done) begin
                r_data_valid <= 1'b1;
                r_data       <= w_rx_data;
                r_parity_err <= !w_par_ok;
                r_ccc_valid  <= r_bcast_frame && w_first_word;
                r_byte_cnt   <= w_cnt_inc;
                r_overflow   <= r_overflow || (32'(w_cnt_inc) >= c_MAX_BYTES);
                r_bit_cnt    <= '0;
                if (w_enthdr_hit) begin
                    r_enthdr   <= 1'b1;
                    r_hdr_mode <= w_rx_data[2:0];
                end
            end

            // START/Sr opens a fresh frame and drops any drive at once
            if (w_start_evt) begin
                r_bit_cnt     <= '0;
                r_byte_cnt    <= '0;
                r_overflow    <= 1'b0;
                r_acked       <= 1'b0;
                r_bcast_frame <= 1'b0;
                r_sda_low     <= 1'b0;
                r_hold_cnt    <= '0;
            end

            if (w_stop_evt || w_hdr_leave) begin
                r_bit_cnt  <= '0;
                r_sda_low  <= 1'b0;
                r_hold_cnt <= '0;
            end
        end
    end

    // Output mapping onto the interface
    always_comb begin
        bus.o_sda_low    = r_sda_low;
        bus.o_addr       = r_addr;
        bus.o_rnw        = r_rnw;
        bus.o_addr_valid = r_addr_valid;
        bus.o_acked      = r_acked;
        bus.o_data       = r_data;
        bus.o_data_valid = r_data_valid;
        bus.o_parity_err = r_parity_err;
        bus.o_ccc_valid  = r_ccc_valid;
        bus.o_enthdr     = r_enthdr;
        bus.o_hdr_mode   = r_hdr_mode;
        bus.o_in_hdr     = (r_state == HDR);
        bus.o_byte_cnt   = r_byte_cnt;
        bus.o_overflow   = r_overflow;
    end

endmodule
`default_nettype wire

// File: doc/sdr_target_frame_responder.md
# sdr_target_frame_responder

Parametrised, synthesizable SDR target-side frame responder for the I3C controller path. It oversamples SCL/SDA on the system clock and detects START, Sr and STOP. It decodes the address byte, ACKs a broadcast 7'h7E or any of N_ADDR programmable dynamic addresses, and decodes 9-bit data words (8 data bits plus T-bit) with an odd-parity check. When it sees ENTHDRx it flags HDR entry. It sits on the open-drain SDA line beside the controller top and replaces ad-hoc bench-side ACK/frame checking with a reusable block.

## Interface
Parameters:
- N_ADDR, 4, number of programmable target addresses
- SYNC_STAGES, 2, SCL/SDA synchroniser depth (≥2)
- ACK_HOLD, 2, system clocks after SCL falling edge before SDA drive changes
- MAX_BYTES, 16, data-word count at which o_overflow asserts

Ports:
- i_sdr_clk  in  1  system clock
- i_sdr_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  block enable; 0 forces IDLE and releases SDA
- i_scl  in  1  SCL line (asynchronous)
- i_sda  in  1  SDA line (asynchronous)
- i_addr_tbl  in  7*N_ADDR  addresses; entry k is bits [7k+6:7k]
- i_addr_vld  in  N_ADDR  per-entry enable
- i_bcast_ack_en  in  1  ACK 7'h7E/W when 1
- i_hdr_exit  in  1  pulse that ends HDR state
- o_sda_low  out  1  1 = pull SDA low; 0 = release
- o_addr  out  7  last received address
- o_rnw  out  1  last received R/W bit
- o_addr_valid  out  1  one-cycle pulse when the address byte is decoded
- o_acked  out  1  level; current frame was ACKed
- o_data  out  8  last data byte
- o_data_valid  out  1  one-cycle pulse per 9-bit word
- o_parity_err  out  1  one-cycle pulse with o_data_valid when T ≠ ~^data
- o_ccc_valid  out  1  one-cycle pulse; first word after 7E/W
- o_enthdr  out  1  one-cycle pulse on a valid ENTHDRx CCC
- o_hdr_mode  out  3  x of the last ENTHDRx
- o_in_hdr  out  1  level while in HDR
- o_byte_cnt  out  5  words in current frame, saturating at 31
- o_overflow  out  1  sticky per frame; o_byte_cnt ≥ MAX_BYTES

## Operation
- Conditions, sampled on synchronised lines:
  - START: SDA falls while SCL is high, from IDLE.
  - Sr: same SDA fall while SCL high, in any other state.
  - STOP: SDA rises while SCL is high.
- Bits are sampled on each SCL rising edge.
- States:
  - IDLE -> ADDR on START/Sr.
  - ADDR: shift 8 bits, MSB first. On the 8th SCL falling edge: pulse o_addr_valid, evaluate match, go to ACK.
  - ACK: on match, drive o_sda_low=1 ACK_HOLD clocks after entering; release ACK_HOLD clocks after the next SCL falling edge.
    - No match: o_sda_low stays 0 and the state returns to IDLE (NACK).
    - Match with rnw=0 -> WDATA. Match with rnw=1 -> RIGNORE.
  - WDATA: shift 9 bits per word, MSB first, T last. On the 9th SCL falling edge: pulse o_data_valid, set o_parity_err, increment o_byte_cnt.
    - Word 1 of a frame addressed to 7E/W: also pulse o_ccc_valid.
    - Word 1 in 8'h20..8'h27 with good parity: pulse o_enthdr, load o_hdr_mode=data[2:0], go to HDR.
  - RIGNORE: no drive; wait for Sr/STOP.
  - HDR: o_in_hdr=1; bit decode suspended; START/Sr ignored; leave to IDLE on i_hdr_exit or STOP.
- Match rules:
  - Match = (addr==7'h7E && rnw==0 && i_bcast_ack_en) or any k with i_addr_vld[k] && addr==entry k.
  - 7E with rnw=1 never matches.
- Sr: from ADDR/ACK/WDATA/RIGNORE -> ADDR. Resets bit counter, o_byte_cnt, o_overflow and o_acked; SDA is released immediately.
- STOP: from any non-IDLE state -> IDLE; SDA released.
- Parity error on an ENTHDR code: o_enthdr is not pulsed; the block stays in WDATA.
- i_en=0, or reset mid-frame: state IDLE, all outputs 0, o_hdr_mode 0.

## Timing
- Input latency: SYNC_STAGES clocks, plus 1 clock for edge detection.
- Pulse outputs are single-cycle, asserted 1 clock after the decoding SCL falling edge is detected.
- o_sda_low changes exactly ACK_HOLD clocks after the detected SCL falling edge.
- Reset values: all outputs 0.
- Simultaneous STOP and i_hdr_exit: IDLE, single transition.
- Bits seen before 8 or 9 are complete and followed by Sr/STOP: discarded, no pulses.
- Each SCL phase must be ≥ SYNC_STAGES+ACK_HOLD+2 clocks. Shorter phases are out of spec.

## Structure
- Package sdr_resp_pkg holds:
  - state enum {IDLE, ADDR, ACK, WDATA, RIGNORE, HDR}
  - BCAST_ADDR=7'h7E
  - ENTHDR_BASE=8'h20
- Sub-module sdr_bus_cond_detect: synchroniser plus edge detection. Outputs scl_rise, scl_fall, start_sr and stop pulses, plus synchronised levels.
- Top contains the FSM, shift registers, counters and the ACK timer.

## Test plan
- 7E/W with i_bcast_ack_en=1, then 9'b0010_0000_0: ACK low for one bit; o_ccc_valid with o_data=8'h20; o_enthdr with o_hdr_mode=0; o_in_hdr=1. A later i_hdr_exit pulse returns the block to IDLE.
- Address 7'h3A/W with entry 2=7'h3A valid, then data 8'h55 T=1: ACK; o_data_valid; o_parity_err=0.
- Same frame with T=0: o_parity_err pulses.
- Address 7'h11 not in table: o_sda_low stays 0; o_addr_valid pulses with o_addr=7'h11; state IDLE.
- 7E/R: NACK. 7E/W with i_bcast_ack_en=0: NACK.
- 20 write words, then Sr, then STOP:
  - o_overflow sets at word 16 and o_byte_cnt reads 20.
  - Sr clears both; STOP returns IDLE.
- Reset asserted mid-ACK: o_sda_low drops asynchronously. A new START after reset decodes normally.
